// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types and the RUN-state priority helper
package cpu_types_pkg;

    localparam int REG_W_DEF = 5;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctl_t;

    typedef struct packed {
        pipe_ctl_t   ctl;
        pipe_state_t nxt;
    } pipe_step_t;

    localparam pipe_ctl_t CTL_FREEZE  = '0;
    localparam pipe_ctl_t CTL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                          exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                          idex_flush: 1'b0, exmem_flush: 1'b0};

    // Shared by RUN (once the dmem miss check passes) and by DWAIT on dhit.
    function automatic pipe_step_t run_priority(input logic br_taken, input logic load_use,
                                                input logic halt, input logic ihit);
        pipe_step_t r;
        r.ctl = CTL_ADVANCE;
        r.nxt = RUN;
        if (br_taken) begin
            r.ctl.pc_en      = ihit;
            r.ctl.ifid_flush = 1'b1;
            r.ctl.idex_flush = 1'b1;
        end else if (load_use) begin
            r.ctl.pc_en      = 1'b0;
            r.ctl.ifid_en    = 1'b0;
            r.ctl.idex_flush = 1'b1;
        end else if (halt) begin
            r.ctl.pc_en      = 1'b0;
            r.ctl.ifid_flush = 1'b1;
            r.nxt            = DRAIN;
        end else if (!ihit) begin
            r.ctl.pc_en      = 1'b0;
            r.ctl.ifid_flush = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between EX load and ID sources
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] wsel,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = mem_read && (wsel != '0) &&
                    ((wsel == rs) || (uses_rt && (wsel == rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer, halt drain FSM and stall-cycle counter
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dreq_mem,
    input  logic             memRead_ex,
    input  logic [REG_W-1:0] wsel_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             usesRt_id,
    input  logic             brTaken_ex,
    input  logic             halt_id,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t state;
    pipe_state_t next_state;
    pipe_ctl_t   ctl;
    pipe_step_t  run_step;
    logic        load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .mem_read (memRead_ex),
        .wsel     (wsel_ex),
        .rs       (rs_id),
        .rt       (rt_id),
        .uses_rt  (usesRt_id),
        .hazard   (load_use)
    );

    assign run_step = run_priority(brTaken_ex, load_use, halt_id, ihit);

    always_comb begin
        ctl        = CTL_FREEZE;
        next_state = state;
        unique case (state)
            RUN: begin
                if (dreq_mem && !dhit) begin
                    next_state = DWAIT;
                end else begin
                    ctl        = run_step.ctl;
                    next_state = run_step.nxt;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    ctl        = run_step.ctl;
                    next_state = run_step.nxt;
                end
            end
            DRAIN: begin
                // IF_ID keeps receiving bubbles while the halt walks toward WB.
                ctl            = CTL_ADVANCE;
                ctl.pc_en      = 1'b0;
                ctl.ifid_flush = 1'b1;
                if (dreq_mem && !dhit) begin
                    ctl.ifid_en  = 1'b0;
                    ctl.idex_en  = 1'b0;
                    ctl.exmem_en = 1'b0;
                    ctl.memwb_en = 1'b0;
                end else if (brTaken_ex) begin
                    ctl.pc_en      = ihit;
                    ctl.idex_flush = 1'b1;
                    next_state     = RUN;
                end else if (halt_wb) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                ctl = CTL_FREEZE;
            end
            default: begin
                ctl        = CTL_FREEZE;
                next_state = RUN;
            end
        endcase
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_flush = ctl.exmem_flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= next_state;
            halted <= (next_state == HALTED);
            if (!ctl.pc_en && (state != HALTED) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dreq_mem, memRead_ex, usesRt_id, brTaken_ex, halt_id, halt_wb;
    logic [4:0]  wsel_ex, rs_id, rt_id;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halted;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halted;
    logic [3:0]  s_stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] stall_exp;

    // Expected bits: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [7:0] ALL  = 8'b1111_1000;
    localparam logic [7:0] FRZ  = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b0011_1010;
    localparam logic [7:0] BR   = 8'b1111_1110;
    localparam logic [7:0] BRNI = 8'b0111_1110;
    localparam logic [7:0] HLT  = 8'b0111_1100;

    typedef struct packed {
        logic [7:0] o;
        logic       h;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .CLK (CLK), .RST (RST), .ihit (ihit), .dhit (dhit), .dreq_mem (dreq_mem),
        .memRead_ex (memRead_ex), .wsel_ex (wsel_ex), .rs_id (rs_id), .rt_id (rt_id),
        .usesRt_id (usesRt_id), .brTaken_ex (brTaken_ex), .halt_id (halt_id), .halt_wb (halt_wb),
        .pc_en (pc_en), .ifid_en (ifid_en), .idex_en (idex_en), .exmem_en (exmem_en),
        .memwb_en (memwb_en), .ifid_flush (ifid_flush), .idex_flush (idex_flush),
        .exmem_flush (exmem_flush), .halted (halted), .stall_cnt (stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4), .REG_W(5)) u_sat (
        .CLK (CLK), .RST (RST), .ihit (ihit), .dhit (dhit), .dreq_mem (dreq_mem),
        .memRead_ex (memRead_ex), .wsel_ex (wsel_ex), .rs_id (rs_id), .rt_id (rt_id),
        .usesRt_id (usesRt_id), .brTaken_ex (brTaken_ex), .halt_id (halt_id), .halt_wb (halt_wb),
        .pc_en (s_pc_en), .ifid_en (s_ifid_en), .idex_en (s_idex_en), .exmem_en (s_exmem_en),
        .memwb_en (s_memwb_en), .ifid_flush (s_ifid_flush), .idex_flush (s_idex_flush),
        .exmem_flush (s_exmem_flush), .halted (s_halted), .stall_cnt (s_stall_cnt)
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dreq_mem = 1'b0; memRead_ex = 1'b0; usesRt_id = 1'b0;
        brTaken_ex = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;
        wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    endtask

    // Inputs are set by the caller just after a rising edge; outputs are checked 2 ns later.
    task automatic step(input string tag, input logic [7:0] exp_o, input logic exp_h);
        exp_t e;
        logic [7:0] obs;
        e.o = exp_o;
        e.h = exp_h;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
        total++;
        assert ((obs === e.o) && (halted === e.h)) else begin
            bad++;
            $error("FAIL %s: ctl=%b halted=%b, expected ctl=%b halted=%b", tag, obs, halted, e.o, e.h);
        end
        total++;
        assert (stall_cnt === stall_exp) else begin
            bad++;
            $error("FAIL %s_stall: stall_cnt=%0d expected %0d", tag, stall_cnt, stall_exp);
        end
        if (!e.o[7] && !e.h) stall_exp = stall_exp + 16'd1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        stall_exp = 16'd0;

        for (int i = 0; i < 5; i++) step("nominal", ALL, 1'b0);

        memRead_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd8;
        step("load_use_rs", LU, 1'b0);
        idle();
        step("after_lu", ALL, 1'b0);
        memRead_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd3; rt_id = 5'd8; usesRt_id = 1'b1;
        step("load_use_rt", LU, 1'b0);
        usesRt_id = 1'b0;
        step("rt_unused", ALL, 1'b0);
        wsel_ex = 5'd0; rs_id = 5'd0;
        step("wsel_zero", ALL, 1'b0);

        idle(); dreq_mem = 1'b1;
        for (int i = 0; i < 3; i++) step("dmiss", FRZ, 1'b0);
        dhit = 1'b1;
        step("dhit", ALL, 1'b0);
        dhit = 1'b0; brTaken_ex = 1'b1;
        step("miss_over_br", FRZ, 1'b0);
        dhit = 1'b1;
        step("dwait_br", BR, 1'b0);

        idle(); ihit = 1'b0;
        step("no_ihit", HLT, 1'b0);
        brTaken_ex = 1'b1;
        step("br_no_ihit", BRNI, 1'b0);
        idle(); brTaken_ex = 1'b1; halt_id = 1'b1;
        step("br_halt", BR, 1'b0);
        idle();
        step("after_br_halt", ALL, 1'b0);

        halt_id = 1'b1;
        step("halt_enter", HLT, 1'b0);
        idle();
        step("drain", HLT, 1'b0);
        brTaken_ex = 1'b1;
        step("drain_cancel", BR, 1'b0);
        idle();
        step("run_again", ALL, 1'b0);

        dreq_mem = 1'b1;
        step("miss2", FRZ, 1'b0);
        dhit = 1'b1; halt_id = 1'b1;
        step("dwait_halt", HLT, 1'b0);
        idle();
        step("drain1", HLT, 1'b0);
        step("drain2", HLT, 1'b0);
        halt_wb = 1'b1;
        step("drain_wb", HLT, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) step("halted", FRZ, 1'b1);

        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        stall_exp = 16'd0;
        total++;
        assert (s_stall_cnt === 4'd0) else begin
            bad++;
            $error("FAIL sat_reset: stall_cnt=%0d expected 0", s_stall_cnt);
        end
        step("post_reset", ALL, 1'b0);

        ihit = 1'b0;
        for (int i = 0; i < 10; i++) step("stall_run", HLT, 1'b0);
        total++;
        assert (s_stall_cnt === 4'd10) else begin
            bad++;
            $error("FAIL sat_mid: stall_cnt=%0d expected 10", s_stall_cnt);
        end
        for (int i = 0; i < 10; i++) step("stall_run", HLT, 1'b0);
        total++;
        assert (s_stall_cnt === 4'd15) else begin
            bad++;
            $error("FAIL sat_top: stall_cnt=%0d expected 15", s_stall_cnt);
        end
        total++;
        assert (stall_cnt === 16'd20) else begin
            bad++;
            $error("FAIL wide_cnt: stall_cnt=%0d expected 20", stall_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB latches and the PC enable from cache handshakes (ihit/dhit), load-use detection, taken branches/jumps and halt.
- Owns the halt drain sequence.
- Keeps a saturating stall-cycle counter for performance reporting.

Parameters:
- CNT_W, 16, width of stall_cnt.
- REG_W, 5, register-index width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- dreq_mem  in  1  MEM-stage instruction reads or writes memory.
- memRead_ex  in  1  EX-stage instruction is a load.
- wsel_ex  in  REG_W  EX-stage destination register.
- rs_id  in  REG_W  ID-stage source register.
- rt_id  in  REG_W  ID-stage second source register.
- usesRt_id  in  1  ID-stage instruction reads rt.
- brTaken_ex  in  1  EX-stage branch or jump redirects the PC.
- halt_id  in  1  ID-stage instruction is halt.
- halt_wb  in  1  halt has reached the MEM_WB output.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control fields 0) when the matching enable is also 1.
- halted  out  1  processor halted; registered.
- stall_cnt  out  CNT_W  cycles in which pc_en=0 while not HALTED.

Behaviour:
- Reset: synchronous. On the clock edge with RST=1:
  - state<=RUN, halted<=0, stall_cnt<=0.
  - Combinational outputs evaluate as RUN state.
- States: RUN, DWAIT, DRAIN, HALTED. All enables and flushes are combinational from the state and inputs; the state register updates on the clock edge.
- RUN priority, highest first:
  1. dreq_mem && !dhit: all enables 0, pc_en=0, next state DWAIT.
  2. brTaken_ex: pc_en=ihit; all enables 1; ifid_flush=1, idex_flush=1. halt_id is ignored (wrong-path halt).
  3. Load-use: memRead_ex && wsel_ex!=0 && (wsel_ex==rs_id || (usesRt_id && wsel_ex==rt_id)).
     - pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1.
     - exmem_en=1, memwb_en=1.
  4. halt_id: pc_en=0, ifid_flush=1, all enables 1, next state DRAIN.
  5. !ihit: pc_en=0, ifid_en=1 with ifid_flush=1, downstream enables 1.
  6. Otherwise: all enables 1, no flush, pc_en=1.
- DWAIT:
  - While dhit=0: everything frozen, all enables 0.
  - On dhit=1: evaluate the RUN priority list 2..6 (item 1 excluded) this cycle, and next state is RUN, or DRAIN if item 4 fires.
- DRAIN:
  - pc_en=0; ifid_flush=1.
  - Downstream stages advance subject to the dreq_mem/dhit freeze, which is identical to item 1 but stays in DRAIN.
  - brTaken_ex in DRAIN cancels the halt: flush IF_ID and ID_EX, pc_en=ihit, next state RUN.
  - halt_wb (with memwb_en high): next state HALTED.
- HALTED:
  - All enables 0, pc_en=0, halted=1.
  - Exited only by RST.
- stall_cnt: increments on every edge where pc_en=0 and state!=HALTED; saturates at all-ones.
- Simultaneous events:
  - A dmem miss overrides a branch. The branch is re-evaluated when dhit arrives, because EX is frozen.
  - Load-use with wsel_ex==0 is not a hazard.
  - RST has priority over every state, including HALTED.

Decomposition:
- cpu_types_pkg gains pipe_state_t (RUN, DWAIT, DRAIN, HALTED) and regbits_t (REG_W wide) if not already present.
- Hazard compare sub-module hazard_detect (purely combinational load-use check); state machine and counter stay in pipeline_ctrl.

Test Plan:
- Reset then ihit=1, no hazards for 5 cycles -> all enables 1, pc_en=1, flushes 0, stall_cnt=0, halted=0.
- memRead_ex=1, wsel_ex=8, rs_id=8 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1 next cycle. Repeat with wsel_ex=0 -> no stall.
- dreq_mem=1, dhit=0 for 3 cycles then dhit=1 -> all enables 0 for 3 cycles, state DWAIT, then full advance; stall_cnt=4.
- brTaken_ex=1 and halt_id=1 same cycle -> ifid_flush=idex_flush=1, state stays RUN, halted stays 0.
- halt_id=1, then halt_wb=1 three cycles later -> DRAIN with pc_en=0 and ifid_flush=1, then halted=1 with all enables 0. RST=1 afterwards -> RUN, halted=0, stall_cnt=0.
- Force stall with CNT_W=4 for 20 cycles -> stall_cnt saturates at 15.
